// File: rtl/jkff_bank_ctrl_pkg.sv
// rtl/jkff_bank_ctrl_pkg.sv - opcode and state encodings for the JKFF bank sequencer
package jkff_bank_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OP_W-1:0] OP_SET    = 3'd1;
  localparam logic [OP_W-1:0] OP_CLR    = 3'd2;
  localparam logic [OP_W-1:0] OP_TOG    = 3'd3;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd4;
  localparam logic [OP_W-1:0] OP_COUNT  = 3'd5;
  localparam logic [OP_W-1:0] OP_CLRALL = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/jk_incr_mask.sv
// rtl/jk_incr_mask.sv - toggle mask that makes a JK bank count up by one
module jk_incr_mask #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_mask
);

  // bit i toggles when every lower bit is 1; bits at or above i are forced to 1 before the AND
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_mask[i] = &(i_q | ~((WIDTH'(1) << i) - WIDTH'(1)));
    end
  end

endmodule

// File: rtl/jkff_bank_ctrl.sv
// rtl/jkff_bank_ctrl.sv - command sequencer for a JKFF bank (optional JKFF_BANK_CTRL_VERIFY_EN)
module jkff_bank_ctrl
  import jkff_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [OP_W-1:0]  i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic [WIDTH-1:0] i_Q,
  output logic [WIDTH-1:0] o_J,
  output logic [WIDTH-1:0] o_K,
  output logic [WIDTH-1:0] o_E,
  output logic             o_bank_reset,
  output logic             o_done,
  output logic             o_wrap,
  output logic             o_err
);

  state_t            r_state;
  state_t            w_state_next;
  logic [OP_W-1:0]   r_op;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  r_remain;
  logic [WIDTH-1:0]  w_incr_mask;
  logic              w_accept;

  // ready is masked by reset so nothing can be taken while the controller is held
  assign o_cmd_ready = (r_state == ST_IDLE) && i_rst_n;
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  jk_incr_mask #(.WIDTH(WIDTH)) u_incr_mask (
    .i_q    (i_Q),
    .o_mask (w_incr_mask)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // latch the command on accept; remaining count steps down once per COUNT cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= OP_NOP;
      r_data   <= '0;
      r_remain <= '0;
    end else if (w_accept) begin
      r_op     <= i_cmd_op;
      r_data   <= i_cmd_data;
      r_remain <= i_cmd_data;
    end else if (r_state == ST_COUNT) begin
      r_remain <= r_remain - WIDTH'(1);
    end
  end

  // next state and bank drive; J=K=0 with E=1 would clear, so idle bits always get E=0
  always_comb begin
    w_state_next = r_state;
    o_J          = '0;
    o_K          = '0;
    o_E          = '0;
    o_bank_reset = 1'b0;
    o_done       = 1'b0;
    o_wrap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((i_cmd_op == OP_COUNT) && (i_cmd_data != '0)) begin
            w_state_next = ST_COUNT;
          end else begin
            w_state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (r_op)
          OP_SET: begin
            o_E = r_data;
            o_J = r_data;
          end
          OP_CLR: begin
            o_E = r_data;
            o_K = r_data;
          end
          OP_TOG: begin
            o_E = r_data;
            o_J = r_data;
            o_K = r_data;
          end
          OP_LOAD: begin
            o_E = '1;
            o_J = r_data;
            o_K = ~r_data;
          end
          OP_CLRALL: begin
            o_bank_reset = 1'b1;
          end
          default: begin
          end
        endcase
        w_state_next = ST_DONE;
      end
      ST_COUNT: begin
        o_E    = w_incr_mask;
        o_J    = w_incr_mask;
        o_K    = w_incr_mask;
        o_wrap = &i_Q;
        if (r_remain == WIDTH'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef JKFF_BANK_CTRL_VERIFY_EN
  logic [WIDTH-1:0] r_expect;
  logic [WIDTH-1:0] w_expect_next;
  logic             r_err;

  // expected bank value after the command, from the Q seen at the accept edge
  always_comb begin
    w_expect_next = i_Q;
    case (i_cmd_op)
      OP_SET:    w_expect_next = i_Q | i_cmd_data;
      OP_CLR:    w_expect_next = i_Q & ~i_cmd_data;
      OP_TOG:    w_expect_next = i_Q ^ i_cmd_data;
      OP_LOAD:   w_expect_next = i_cmd_data;
      OP_COUNT:  w_expect_next = i_Q + i_cmd_data;
      OP_CLRALL: w_expect_next = '0;
      default:   w_expect_next = i_Q;
    endcase
  end

  // capture expectation on accept; flag a sticky error if DONE sees a different Q
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_expect <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_expect <= w_expect_next;
      r_err    <= 1'b0;
    end else if ((r_state == ST_DONE) && (i_Q != r_expect)) begin
      r_err    <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/jkff_bank_ctrl.md
Name: jkff_bank_ctrl

Overview:
Command sequencer for a WIDTH-bit bank of JKFF cells sharing one clock. Accepts one command at a time over a valid/ready handshake and drives the bank's per-bit J, K and E vectors and its reset to perform set, clear, toggle, load, clear-all and multi-step count. Sits between a register-file/bus decoder and the JKFF bank, and reads the bank's Q back for counting and completion.

Parameters:
WIDTH, 8, bank width in bits; also the width of cmd_data and of the count operand.

Ports:
_clock  input  1  bank and controller clock, rising edge.
_reset  input  1  asynchronous, active-low controller reset.
_cmd_valid  input  1  command present.
_cmd_ready  output  1  high only in IDLE; accept = valid & ready at a rising edge.
_cmd_op  input  3  opcode: 0 NOP, 1 SET, 2 CLR, 3 TOG, 4 LOAD, 5 COUNT, 6 CLRALL, 7 reserved (executes as NOP).
_cmd_data  input  WIDTH  mask for SET/CLR/TOG, value for LOAD, step count for COUNT.
_Q  input  WIDTH  bank Q readback.
_J  output  WIDTH  bank J vector.
_K  output  WIDTH  bank K vector.
_E  output  WIDTH  bank per-bit enable.
_bank_reset  output  1  drives the bank's synchronous active-high reset.
_done  output  1  one-cycle pulse; _Q reflects the completed command.
_wrap  output  1  one-cycle pulse on a COUNT step from all-ones to zero.

Behaviour:
- Bank rule, E=1: J&~K sets; ~J&K clears; J&K toggles; J=K=0 clears, not holds. Hold is achieved only with E=0. Every bit outside the op mask is driven E=0.
- States: IDLE, EXEC, COUNT, DONE. Registers hold the state, the op, the operand and the remaining count.
- _J, _K, _E and _bank_reset are combinational from registered state, the latched operand and _Q only. There is no path from the _cmd_* inputs.
- IDLE: _E=0, _bank_reset=0. On accept, latch op and data, then go to EXEC. COUNT with data≠0 goes to COUNT; COUNT with data=0 goes to EXEC and acts as NOP.
- EXEC, one cycle, with the bank updating at the end-of-cycle edge:
  - SET: E=J=m, K=0.
  - CLR: E=K=m, J=0.
  - TOG: E=J=K=m.
  - LOAD: E=all-ones, J=v, K=~v.
  - CLRALL: E=0, _bank_reset=1.
  - NOP/reserved: E=0.
  - Next state is DONE.
- COUNT: each cycle, toggle mask t[i] = AND of _Q[i-1:0], with t[0]=1; E=J=K=t. Decrement remaining count. _wrap=1 in a cycle where _Q is all-ones. Go to DONE after the step where remaining reaches 1.
- DONE: _done=1 for one cycle, E=0, then IDLE. Latency from the accept edge: 3 cycles to _done for single-step ops; n+2 for COUNT n.
- _cmd_valid while not ready is ignored; the command is not queued.
- _reset low at any time: immediately go to IDLE; _J=_K=_E=0, _bank_reset=0, _done=_wrap=0, _cmd_ready=0 while low. Bank contents hold (E=0). _cmd_ready=1 from the first cycle after release.
- Count step width is WIDTH; wrap is modulo 2^WIDTH.

Optional Feature:
JKFF_BANK_CTRL_VERIFY_EN:
- Defined: adds an expected-value register computed at the accept edge from the pre-op _Q:
  - SET: Q|m
  - CLR: Q&~m
  - TOG: Q^m
  - LOAD: v
  - CLRALL: 0
  - COUNT: Q+n mod 2^W
  - NOP: Q
- Output _err (1 bit) is set in DONE if _Q≠expected; it is sticky until the next accept or reset.
- Undefined: _err is tied 0 and no expected-value logic exists. The port list is identical in both builds.

Decomposition:
- Package jkff_bank_ctrl_pkg: opcode constants, state encoding constants, op width of 3.
- Sub-module jk_incr_mask: combinational WIDTH-bit toggle-mask generator from Q, reusable for other JK counters.

Test Plan:
- Reset low for 3 cycles, then release → during reset _E=_J=_K=0, _cmd_ready=0; the cycle after release _cmd_ready=1 and _done=0.
- Q=0x00, LOAD 0xA5 → EXEC cycle shows E=0xFF, J=0xA5, K=0x5A; Q=0xA5; _done pulses exactly once, 3 cycles after accept.
- Q=0xA5, SET 0x0F then TOG 0xFF → Q=0xAF then 0x50; the SET cycle shows E=0x0F; upper nibble is never enabled.
- Q=0xFE, COUNT 3 → Q sequence FF, 00, 01; _wrap pulses once on the FF→00 step; _done at accept+5. COUNT 0 → Q unchanged, _done at accept+3.
- CLRALL with Q=0x3C → _bank_reset=1 for one cycle with E=0; Q=0x00; with VERIFY_EN, _err stays 0.
- COUNT 5 from 0x10; assert reset after 2 steps → outputs 0 immediately; Q holds 0x12; a command held valid during reset is not accepted; ready returns after release.
